// File: rtl/demuxn.sv
// Token demultiplexer: joins a data token with a destination index and forwards it
// over one of M four-phase return-to-zero output channels, counting unroutable tokens.
module demuxn #(
    parameter int N  = 1,
    parameter int M  = 4,
    parameter int SW = 2,
    parameter int CW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           r_i,
    output logic           a_i,
    input  logic [N-1:0]   d_i,
    input  logic           rctl_i,
    input  logic [SW-1:0]  dctl_i,
    output logic           actl_i,
    output logic [M-1:0]   r_o,
    input  logic [M-1:0]   a_o,
    output logic [M*N-1:0] d_o,
    output logic [CW-1:0]  drop_cnt,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RTZ  = 2'd2,
        ACK  = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   dreg_q, dreg_d;
    logic [SW-1:0]  sreg_q, sreg_d;
    logic [CW-1:0]  drop_cnt_q, drop_cnt_d;
    logic [M-1:0]   r_o_q, r_o_d;
    logic [M*N-1:0] d_o_q, d_o_d;
    logic           a_i_q, a_i_d;
    logic           actl_i_q, actl_i_d;
    logic           busy_q, busy_d;

    logic           capture;
    logic           in_range;
    logic           sel_ack;
    logic           drop_sat;
    logic [M-1:0]   ch_d;

    assign capture  = r_i && rctl_i;
    assign drop_sat = (drop_cnt_q == {CW{1'b1}});

    // Index decode by loop keeps non-power-of-two M free of out-of-range selects.
    always_comb begin
        in_range = 1'b0;
        sel_ack  = 1'b0;
        for (int k = 0; k < M; k++) begin
            if (dctl_i == SW'(k)) in_range = 1'b1;
            if (sreg_q == SW'(k)) sel_ack  = a_o[k];
        end
    end

    // NOTE: every variable gets its hold value before the case, so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        dreg_d     = dreg_q;
        sreg_d     = sreg_q;
        drop_cnt_d = drop_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    dreg_d = d_i;
                    sreg_d = dctl_i;
                    if (in_range) begin
                        state_d = SEND;
                    end else begin
                        state_d = ACK;
                        if (!drop_sat) drop_cnt_d = drop_cnt_q + CW'(1);
                    end
                end
            end
            SEND:    if (sel_ack) state_d = RTZ;
            RTZ:     if (!sel_ack) state_d = ACK;
            ACK:     if (!r_i && !rctl_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are a pure image of the next state, so they change on the same edge.
    always_comb begin
        for (int k = 0; k < M; k++) begin
            ch_d[k] = (sreg_d == SW'(k));
        end
        r_o_d = (state_d == SEND) ? ch_d : '0;
        d_o_d = '0;
        for (int k = 0; k < M; k++) begin
            if ((state_d == SEND || state_d == RTZ) && ch_d[k]) d_o_d[k*N +: N] = dreg_d;
        end
        a_i_d    = (state_d == ACK);
        actl_i_d = (state_d == ACK);
        busy_d   = (state_d != IDLE);
    end

    // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            dreg_q     <= '0;
            sreg_q     <= '0;
            drop_cnt_q <= '0;
            r_o_q      <= '0;
            d_o_q      <= '0;
            a_i_q      <= 1'b0;
            actl_i_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dreg_q     <= dreg_d;
            sreg_q     <= sreg_d;
            drop_cnt_q <= drop_cnt_d;
            r_o_q      <= r_o_d;
            d_o_q      <= d_o_d;
            a_i_q      <= a_i_d;
            actl_i_q   <= actl_i_d;
            busy_q     <= busy_d;
        end
    end

    assign a_i      = a_i_q;
    assign actl_i   = actl_i_q;
    assign r_o      = r_o_q;
    assign d_o      = d_o_q;
    assign drop_cnt = drop_cnt_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_demuxn.sv
// Directed bench for demuxn: a 4-channel byte instance and a 3-channel instance
// with a 2-bit drop counter, checked with immediate assertions.
module tb_demuxn;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // Instance A: N=8, M=4, SW=2, CW=8
    logic        a_r_i, a_a_i, a_rctl_i, a_actl_i, a_busy;
    logic [7:0]  a_d_i, a_drop;
    logic [1:0]  a_dctl_i;
    logic [3:0]  a_r_o, a_a_o;
    logic [31:0] a_d_o;

    // Instance B: N=8, M=3, SW=2, CW=2
    logic        b_r_i, b_a_i, b_rctl_i, b_actl_i, b_busy;
    logic [7:0]  b_d_i;
    logic [1:0]  b_dctl_i, b_drop;
    logic [2:0]  b_r_o, b_a_o;
    logic [23:0] b_d_o;

    demuxn #(.N(8), .M(4), .SW(2), .CW(8)) dut_a (
        .clk(clk), .rst(rst),
        .r_i(a_r_i), .a_i(a_a_i), .d_i(a_d_i),
        .rctl_i(a_rctl_i), .dctl_i(a_dctl_i), .actl_i(a_actl_i),
        .r_o(a_r_o), .a_o(a_a_o), .d_o(a_d_o),
        .drop_cnt(a_drop), .busy(a_busy)
    );

    demuxn #(.N(8), .M(3), .SW(2), .CW(2)) dut_b (
        .clk(clk), .rst(rst),
        .r_i(b_r_i), .a_i(b_a_i), .d_i(b_d_i),
        .rctl_i(b_rctl_i), .dctl_i(b_dctl_i), .actl_i(b_actl_i),
        .r_o(b_r_o), .a_o(b_a_o), .d_o(b_d_o),
        .drop_cnt(b_drop), .busy(b_busy)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_drop;
        rst = 1'b0;
        a_r_i = 0; a_rctl_i = 0; a_d_i = '0; a_dctl_i = '0; a_a_o = '0;
        b_r_i = 0; b_rctl_i = 0; b_d_i = '0; b_dctl_i = '0; b_a_o = '0;
        tick();
        tick();

        // Reset state
        chk("rst_a_r_o",   {28'd0, a_r_o}, 64'h0);
        chk("rst_a_d_o",   a_d_o, 64'h0);
        chk("rst_a_ack",   {a_a_i, a_actl_i, a_busy}, 64'h0);
        chk("rst_a_drop",  a_drop, 64'h0);
        chk("rst_b_drop",  b_drop, 64'h0);
        rst = 1'b1;

        // Basic token to channel 2
        a_d_i = 8'hA5; a_dctl_i = 2'd2; a_r_i = 1; a_rctl_i = 1;
        tick();
        chk("t2_r_o",  a_r_o, 64'h4);
        chk("t2_d_o",  a_d_o, 64'h00A5_0000);
        chk("t2_busy", {a_busy, a_a_i, a_actl_i}, 64'b100);
        a_a_o = 4'b0100;
        tick();
        chk("t2_rtz_r_o", a_r_o, 64'h0);
        chk("t2_rtz_d_o", a_d_o, 64'h00A5_0000);
        a_a_o = 4'b0000;
        tick();
        chk("t2_ack", {a_a_i, a_actl_i, a_busy}, 64'b111);
        a_r_i = 0; a_rctl_i = 0;
        tick();
        chk("t2_idle", {a_a_i, a_actl_i, a_busy}, 64'b000);

        // Join: data alone must not start a token
        a_d_i = 8'h3C; a_dctl_i = 2'd1; a_r_i = 1; a_rctl_i = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("join_hold", {a_busy, a_a_i, a_actl_i, a_r_o, a_d_o}, 64'h0);
        end
        a_rctl_i = 1;
        tick();
        chk("join_r_o", a_r_o, 64'h2);
        chk("join_d_o", a_d_o, 64'h0000_3C00);

        // Foreign acks and input changes during SEND are ignored
        a_a_o = 4'b1001; a_d_i = 8'hFF; a_dctl_i = 2'd3;
        tick();
        chk("ign_r_o", a_r_o, 64'h2);
        chk("ign_d_o", a_d_o, 64'h0000_3C00);
        a_a_o = 4'b0010;
        tick();
        chk("ign_rtz_r_o", a_r_o, 64'h0);
        chk("ign_rtz_d_o", a_d_o, 64'h0000_3C00);
        a_a_o = 4'b0000;
        tick();
        chk("ign_ack", {a_a_i, a_actl_i}, 64'b11);
        a_r_i = 0;
        tick();
        chk("ack_half", {a_a_i, a_actl_i, a_busy}, 64'b111);
        a_rctl_i = 0;
        tick();
        chk("ign_idle", {a_a_i, a_actl_i, a_busy}, 64'b000);

        // Acks in IDLE are ignored
        a_a_o = 4'hF;
        tick();
        tick();
        chk("idle_ack_ign", {a_busy, a_r_o, a_d_o}, 64'h0);
        a_a_o = 4'h0;

        // Asynchronous reset mid-token, then a fresh token
        a_d_i = 8'h77; a_dctl_i = 2'd3; a_r_i = 1; a_rctl_i = 1;
        tick();
        chk("pre_rst_r_o", a_r_o, 64'h8);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst", {a_busy, a_a_i, a_actl_i, a_r_o, a_d_o}, 64'h0);
        a_d_i = 8'h11; a_dctl_i = 2'd0;
        tick();
        chk("rst_hold", {a_busy, a_a_i, a_actl_i, a_r_o, a_d_o}, 64'h0);
        rst = 1'b1;
        tick();
        chk("post_rst_r_o", a_r_o, 64'h1);
        chk("post_rst_d_o", a_d_o, 64'h0000_0011);
        a_a_o = 4'b0001;
        tick();
        chk("post_rst_rtz", a_r_o, 64'h0);
        a_a_o = 4'b0000;
        tick();
        chk("post_rst_ack", {a_a_i, a_actl_i}, 64'b11);
        a_r_i = 0; a_rctl_i = 0;
        tick();
        chk("post_rst_idle", {a_a_i, a_actl_i, a_busy}, 64'b000);

        // Back-to-back tokens, zero-delay environment: 4 clocks each
        for (int k = 0; k < 4; k++) begin
            logic [31:0] exp_d;
            logic [3:0]  exp_r;
            exp_d = 32'(8'h10 + k) << (8 * k);
            exp_r = 4'b0001 << k;
            a_d_i = 8'(8'h10 + k); a_dctl_i = 2'(k); a_r_i = 1; a_rctl_i = 1;
            tick();
            chk("b2b_send", {a_r_o, a_d_o}, {28'd0, exp_r, exp_d});
            a_a_o = exp_r;
            tick();
            chk("b2b_rtz", {a_busy, a_r_o, a_d_o}, {27'd0, 1'b1, 4'b0000, exp_d});
            a_a_o = 4'b0000;
            tick();
            chk("b2b_ack", {a_a_i, a_actl_i, a_r_o}, 64'b11_0000);
            a_r_i = 0; a_rctl_i = 0;
            tick();
            chk("b2b_idle", {a_a_i, a_actl_i, a_busy, a_r_o}, 64'h0);
        end
        chk("b2b_no_drop", a_drop, 64'h0);

        // Out-of-range index on the 3-channel instance, saturating 2-bit counter
        exp_drop = 2'd0;
        for (int i = 0; i < 5; i++) begin
            if (exp_drop != 2'd3) exp_drop = exp_drop + 2'd1;
            b_d_i = 8'(i); b_dctl_i = 2'd3; b_r_i = 1; b_rctl_i = 1;
            tick();
            chk("drop_cnt", b_drop, {62'd0, exp_drop});
            chk("drop_ack", {b_a_i, b_actl_i, b_busy, b_r_o, b_d_o}, {37'd0, 3'b111, 3'b000, 24'h0});
            b_r_i = 0; b_rctl_i = 0;
            tick();
            chk("drop_idle", {b_a_i, b_actl_i, b_busy}, 64'b000);
        end
        chk("drop_final", b_drop, 64'd3);

        // Legal token on the 3-channel instance, top channel
        b_d_i = 8'h5A; b_dctl_i = 2'd2; b_r_i = 1; b_rctl_i = 1;
        tick();
        chk("b_send", {b_r_o, b_d_o}, {37'd0, 3'b100, 24'h5A_0000});
        b_a_o = 3'b100;
        tick();
        chk("b_rtz", b_r_o, 64'h0);
        b_a_o = 3'b000;
        tick();
        chk("b_ack", {b_a_i, b_actl_i, b_drop}, 64'b11_11);
        b_r_i = 0; b_rctl_i = 0;
        tick();
        chk("b_idle", {b_a_i, b_actl_i, b_busy}, 64'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/demuxn.md
DEMUXN -- requirements
Module: demuxn

Interface
REQ-001 SHALL have parameter N, default 1: data width of input and each output channel.
REQ-002 SHALL have parameter M, default 4: number of output channels; legal range 2..256.
REQ-003 SHALL have parameter SW, default 2: select width; SW SHALL equal ceil(log2(M)).
REQ-004 SHALL have parameter CW, default 8: width of the drop counter.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1: reset is asynchronous and active-low (rst=0 => reset).
REQ-007 SHALL have ports r_i (in, 1), a_i (out, 1), d_i (in, N): input data channel.
REQ-008 SHALL have ports rctl_i (in, 1), dctl_i (in, SW), actl_i (out, 1): control channel; dctl_i is the destination index.
REQ-009 SHALL have ports r_o (out, M), a_o (in, M), d_o (out, M*N): output channels; channel k uses r_o[k], a_o[k], d_o[k*N +: N].
REQ-010 SHALL have port drop_cnt (out, CW): number of tokens discarded for an out-of-range index.
REQ-011 SHALL have port busy (out, 1): high in every state except IDLE.

Function
REQ-012 All channels SHALL use four-phase return-to-zero handshakes; every input is synchronous to clk; every output SHALL be a register.
REQ-013 States SHALL be IDLE, SEND, RTZ, ACK; no others.
REQ-014 IDLE: when r_i=1 and rctl_i=1 at a clock edge, SHALL latch d_i into dreg and dctl_i into sreg on that edge.
REQ-015 IDLE with only one of r_i or rctl_i high SHALL stay in IDLE and hold all outputs (join of data and control).
REQ-016 IDLE capture with dctl_i<M SHALL go to SEND; r_o[dctl_i] SHALL be 1 in the cycle after the capture edge (latency 1).
REQ-017 IDLE capture with dctl_i>=M SHALL go directly to ACK; drop_cnt SHALL increment by 1 on that edge and saturate at 2^CW-1; no r_o bit SHALL rise.
REQ-018 SEND: r_o[sreg]=1; d_o channel sreg SHALL carry dreg; all other d_o channels SHALL be 0; d_o SHALL be stable from r_o rise until a_o[sreg] falls.
REQ-019 SEND with a_o[sreg]=1 SHALL go to RTZ; r_o[sreg] SHALL be 0 in the next cycle.
REQ-020 RTZ with a_o[sreg]=0 SHALL go to ACK; a_i and actl_i SHALL both be 1 in the next cycle.
REQ-021 ACK with r_i=0 and rctl_i=0 SHALL go to IDLE; a_i and actl_i SHALL be 0 in the next cycle; with only one of them low, SHALL stay in ACK.
REQ-022 a_o bits of non-selected channels SHALL be ignored in every state; an a_o bit high in IDLE SHALL be ignored.
REQ-023 At most one r_o bit SHALL be high at any time.
REQ-024 d_i and dctl_i changes after the capture edge SHALL NOT affect d_o or routing until the next capture.
REQ-025 Minimum token cycle SHALL be 4 clocks (capture, SEND, RTZ, ACK), given zero-delay environment responses.

Reset
REQ-026 rst=0 SHALL asynchronously force state IDLE, r_o=0, d_o=0, a_i=0, actl_i=0, busy=0, drop_cnt=0, dreg=0, sreg=0.
REQ-027 rst=0 in any state mid-token SHALL abandon the token with no further handshake edges; after rst rises, the first edge with r_i=1 and rctl_i=1 SHALL capture a new token.
REQ-028 Deassertion of rst SHALL take effect on the first rising clk edge after deassertion; no output SHALL change while rst=0.

Verification
REQ-029 M=4, N=8: d_i=0xA5, dctl_i=2, r_i=rctl_i=1 -> next cycle r_o=4'b0100, d_o channel 2=0xA5, others 0; a_o[2]=1 -> r_o=0; a_o[2]=0 -> a_i=actl_i=1; r_i=rctl_i=0 -> a_i=actl_i=0, busy=0.
REQ-030 M=3, SW=2: dctl_i=3 with r_i=rctl_i=1 -> no r_o rise, drop_cnt 0->1, a_i=actl_i=1 next cycle; CW=2 with five such drops -> drop_cnt=3.
REQ-031 r_i=1 with rctl_i=0 for 10 cycles, then rctl_i=1, dctl_i=1 -> no output change for 10 cycles, r_o=4'b0010 one cycle after rctl_i rises.
REQ-032 In SEND to channel 1, raise a_o[0] and a_o[3] -> no state change; change d_i to 0xFF -> d_o channel 1 unchanged.
REQ-033 rst=0 while in SEND to channel 3 -> r_o=0, d_o=0, busy=0 immediately without a clock edge; after rst=1, new token to channel 0 completes normally.
REQ-034 Back-to-back tokens to channels 0,1,2,3 with same-cycle environment responses -> each token takes exactly 4 clocks; r_o one-hot or zero throughout.
